// File: rtl/rect_fill_writer.sv
// Rectangle-fill frame-buffer writer: one pixel write per clock, clipped to FB_W x FB_H.
// Latency: first pixel on mem_* the cycle after accept; done pulses one cycle after the last pixel.
// Backpressure: cmd_ready is low while filling and in the done cycle; held commands wait, never dropped.
// Optional build macro RECT_FILL_CHECKER_EN adds cmd_color_alt for a checkerboard fill.
module rect_fill_writer #(
   parameter int FB_W       = 320,
   parameter int FB_H       = 240,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [9:0]            cmd_x,
   input  logic [8:0]            cmd_y,
   input  logic [9:0]            cmd_w,
   input  logic [8:0]            cmd_h,
   input  logic [DATA_WIDTH-1:0] cmd_color,
`ifdef RECT_FILL_CHECKER_EN
   input  logic [DATA_WIDTH-1:0] cmd_color_alt,
`endif
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [9:0]            x_q, x_d;
   logic [8:0]            y_q, y_d;
   logic [9:0]            w_q, w_d;
   logic [8:0]            h_q, h_d;
   logic [9:0]            col_q, col_d;
   logic [8:0]            row_q, row_d;
   logic [DATA_WIDTH-1:0] color_q, color_d;
`ifdef RECT_FILL_CHECKER_EN
   logic [DATA_WIDTH-1:0] alt_q, alt_d;
`endif

   logic [10:0]           px;
   logic [9:0]            py;
   logic                  in_bounds;
   logic                  last_pos;
   logic [ADDR_WIDTH-1:0] pix_addr;
   logic [DATA_WIDTH-1:0] pix_data;

   // Pixel coordinate, clip test and address; widened so x+col can never wrap back on-screen.
   always_comb begin
      px        = {1'b0, x_q} + {1'b0, col_q};
      py        = {1'b0, y_q} + {1'b0, row_q};
      in_bounds = (32'(px) < 32'(FB_W)) && (32'(py) < 32'(FB_H));
      pix_addr  = ADDR_WIDTH'(32'(py) * 32'(FB_W) + 32'(px));
      last_pos  = (col_q == w_q - 10'd1) && (row_q == h_q - 9'd1);
`ifdef RECT_FILL_CHECKER_EN
      // Parity follows the rectangle-relative counters so the pattern is anchored to the rectangle.
      pix_data  = (col_q[0] ^ row_q[0]) ? alt_q : color_q;
`else
      pix_data  = color_q;
`endif
   end

   // State and captured-command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         color_q <= '0;
`ifdef RECT_FILL_CHECKER_EN
         alt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         row_q   <= row_d;
         color_q <= color_d;
`ifdef RECT_FILL_CHECKER_EN
         alt_q   <= alt_d;
`endif
      end
   end

   // Next-state, raster counters and outputs; memory outputs stay zero outside FILL.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      w_d       = w_q;
      h_d       = h_q;
      col_d     = col_q;
      row_d     = row_q;
      color_d   = color_q;
`ifdef RECT_FILL_CHECKER_EN
      alt_d     = alt_q;
`endif
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               x_d     = cmd_x;
               y_d     = cmd_y;
               w_d     = cmd_w;
               h_d     = cmd_h;
               color_d = cmd_color;
`ifdef RECT_FILL_CHECKER_EN
               alt_d   = cmd_color_alt;
`endif
               col_d   = '0;
               row_d   = '0;
               // Empty rectangles skip straight to the completion pulse.
               state_d = (cmd_w == 10'd0 || cmd_h == 9'd0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            busy      = 1'b1;
            // Clipped positions still take their cycle so timing is data independent.
            mem_we    = in_bounds;
            mem_addr  = pix_addr;
            mem_wdata = pix_data;
            if (last_pos) begin
               state_d = S_DONE;
            end else if (col_q == w_q - 10'd1) begin
               col_d = '0;
               row_d = row_q + 9'd1;
            end else begin
               col_d = col_q + 10'd1;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer: directed cases plus randomized commands
// checked cycle by cycle against a plain-arithmetic raster/clip model.
// Build with RECT_FILL_CHECKER_EN defined to exercise the checkerboard colour path.
module tb_rect_fill_writer;

   localparam int W = 320;
   localparam int H = 240;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [9:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [11:0] cmd_color;
   logic [11:0] cmd_color_alt;
   logic [16:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;
   int wr_addr_log[$];
   int wr_data_log[$];

   rect_fill_writer #(.FB_W(W), .FB_H(H), .ADDR_WIDTH(17), .DATA_WIDTH(12)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_x        (cmd_x),
      .cmd_y        (cmd_y),
      .cmd_w        (cmd_w),
      .cmd_h        (cmd_h),
      .cmd_color    (cmd_color),
`ifdef RECT_FILL_CHECKER_EN
      .cmd_color_alt(cmd_color_alt),
`endif
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference colour for relative position (col,row).
   function automatic int ref_color(input int col, input int row, input int c, input int a);
`ifdef RECT_FILL_CHECKER_EN
      return (((col ^ row) & 1) == 1) ? a : c;
`else
      return c;
`endif
   endfunction

   // Issue one command from idle and check every cycle through completion.
   task automatic run_cmd(input int x, input int y, input int w, input int h,
                          input int color, input int alt);
      int n, col, row, px, py;
      logic exp_we;
      @(negedge clk);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
      cmd_color = 12'(color); cmd_color_alt = 12'(alt);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = w * h;
      for (int k = 0; k < n; k++) begin
         col = k % w;
         row = k / w;
         px = x + col;
         py = y + row;
         exp_we = (px < W) && (py < H);
         chk("fill_we", mem_we, exp_we);
         if (mem_we === 1'b1) begin
            wr_addr_log.push_back(int'(mem_addr));
            wr_data_log.push_back(int'(mem_wdata));
         end
         if (exp_we) begin
            chk("fill_addr", mem_addr, py * W + px);
            chk("fill_data", mem_wdata, ref_color(col, row, color, alt));
         end
         chk("fill_busy", busy, 1);
         chk("fill_ready", cmd_ready, 0);
         chk("fill_done", done, 0);
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("done_we", mem_we, 0);
      chk("done_busy", busy, 1);
      chk("done_ready", cmd_ready, 0);
      @(negedge clk);
      chk("post_ready", cmd_ready, 1);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
   endtask

   task automatic check_log(input string tag, input int exp_a[$], input int exp_d[$]);
      chk({tag, "_count"}, wr_addr_log.size(), exp_a.size());
      if (wr_addr_log.size() == exp_a.size()) begin
         foreach (exp_a[i]) begin
            chk({tag, "_addr"}, wr_addr_log[i], exp_a[i]);
            if (exp_d.size() > i) chk({tag, "_data"}, wr_data_log[i], exp_d[i]);
         end
      end
      wr_addr_log.delete();
      wr_data_log.delete();
   endtask

   initial begin
      int we_cnt, done_cnt, x, y, w, h;
      int exp_we_seq[6], exp_dn_seq[6], exp_rd_seq[6];
      rst = 1'b1; cmd_valid = 1'b0;
      cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0; cmd_color_alt = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);

      // 2x2 at origin
      run_cmd(0, 0, 2, 2, 12'hF00, 12'hF00);
      check_log("t_2x2", '{0, 1, 320, 321}, '{12'hF00, 12'hF00, 12'hF00, 12'hF00});
      // zero width
      run_cmd(10, 10, 0, 5, 12'h123, 12'h123);
      check_log("t_w0", '{}, '{});
      // right clip
      run_cmd(318, 0, 4, 1, 12'h0A0, 12'h0A0);
      check_log("t_rclip", '{318, 319}, '{});
      // bottom clip
      run_cmd(5, 239, 1, 3, 12'h00B, 12'h00B);
      check_log("t_bclip", '{76485}, '{});
`ifdef RECT_FILL_CHECKER_EN
      run_cmd(0, 0, 2, 2, 12'h000, 12'hFFF);
      check_log("t_chk", '{0, 1, 320, 321}, '{12'h000, 12'hFFF, 12'hFFF, 12'h000});
`endif

      // Two 1x1 commands with cmd_valid held high throughout.
      exp_we_seq = '{1, 0, 0, 1, 0, 0};
      exp_dn_seq = '{0, 1, 0, 0, 1, 0};
      exp_rd_seq = '{0, 0, 1, 0, 0, 1};
      we_cnt = 0; done_cnt = 0;
      @(negedge clk);
      cmd_x = 10'd7; cmd_y = 9'd3; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 12'h456;
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("b2b_we", mem_we, exp_we_seq[i]);
         chk("b2b_done", done, exp_dn_seq[i]);
         chk("b2b_ready", cmd_ready, exp_rd_seq[i]);
         if (mem_we === 1'b1) we_cnt++;
         if (done === 1'b1) done_cnt++;
         if (i == 0) begin cmd_x = 10'd8; cmd_y = 9'd4; end
         if (i == 3) begin
            chk("b2b_addr2", mem_addr, 4 * W + 8);
            cmd_valid = 1'b0;
         end
      end
      chk("b2b_writes", we_cnt, 2);
      chk("b2b_dones", done_cnt, 2);

      // Reset after the third write of a 10x10 fill.
      @(negedge clk);
      cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd10; cmd_h = 9'd10; cmd_color = 12'h777;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      we_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (mem_we === 1'b1) we_cnt++;
         if (i < 2) @(negedge clk);
      end
      chk("rst_mid_writes", we_cnt, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_ready", cmd_ready, 1);
      chk("rst_mid_we", mem_we, 0);
      chk("rst_mid_done", done, 0);
      we_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         if (mem_we === 1'b1) we_cnt++;
         if (done === 1'b1) done_cnt++;
      end
      chk("rst_mid_no_wr", we_cnt, 0);
      chk("rst_mid_no_done", done_cnt, 0);

      // Reset wins over a simultaneous command.
      cmd_w = 10'd3; cmd_h = 9'd3; cmd_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cmd_valid = 1'b0;
      chk("rst_vs_cmd_busy", busy, 0);
      chk("rst_vs_cmd_we", mem_we, 0);

      // Randomized commands, biased toward the right/bottom edges.
      for (int t = 0; t < 60; t++) begin
         x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(300, 325));
         y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(225, 245));
         w = int'($urandom_range(0, 12));
         h = int'($urandom_range(0, 8));
         run_cmd(x, y, w, h, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
         wr_addr_log.delete();
         wr_data_log.delete();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rect_fill_writer.md
Name: rect_fill_writer

Overview:
- Frame-buffer writer. Accepts rectangle-fill commands over a valid/ready handshake and writes one 12-bit pixel per clock into an sram port.
- The write port uses addr/write_en/data_in with row-major addressing, addr = y*FB_W + x.
- VGA display readers scan the same memory back out. This block is the producing end of that memory.
- Clips against the frame-buffer bounds, so partially off-screen rectangles are safe.

Parameters:
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- ADDR_WIDTH, 17, sram address width; must satisfy 2^ADDR_WIDTH >= FB_W*FB_H
- DATA_WIDTH, 12, pixel width (RGB444)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x  in  10  left column
- cmd_y  in  9  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in pixels
- cmd_color  in  DATA_WIDTH  fill colour
- mem_addr  out  ADDR_WIDTH  sram address
- mem_we  out  1  sram write enable
- mem_wdata  out  DATA_WIDTH  sram write data
- busy  out  1  high while in FILL or DONE
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - After reset: state IDLE, cmd_ready=1, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, capture cmd_x/y/w/h/color and clear the column and row counters.
  - If w==0 or h==0, go to DONE; otherwise go to FILL.
  - cmd_ready is 0 in FILL and DONE. A command presented then is held off, not dropped.
- FILL:
  - Visits N=w*h positions in raster order: column counter 0..w-1 inner, row counter 0..h-1 outer, one position per cycle.
  - Counting cycles from the accept edge (cycle 1 is the first full cycle after it), position k is presented on mem_* in cycle k+1.
  - Position (col,row) maps to px=x+col (11-bit) and py=y+row (10-bit).
  - In bounds (px<FB_W and py<FB_H): mem_we=1, mem_addr=py*FB_W+px truncated to ADDR_WIDTH, mem_wdata=colour.
  - Out of bounds: mem_we=0 and the cycle is still consumed, so timing does not depend on the data.
  - After the last position (col=w-1, row=h-1), go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, mem_we=0.
  - Then return to IDLE.
  - For N>0, done is in cycle N+1; for N=0, done is in cycle 1.
  - cmd_ready is 1 again in the next cycle, so back-to-back commands have a one-cycle gap.
- mem_we=0 in every cycle outside FILL.
- mem_addr and mem_wdata are don't-care when mem_we=0, but must not be X after reset.
- Arithmetic: compute px and py at full width before the bounds compare, so x+col never wraps. The width parameters support w up to 1023 and h up to 511.
- Reset mid-operation: the next cycle is IDLE with mem_we=0, done=0, cmd_ready=1. No further writes occur and no done pulse is produced.
- Simultaneous cmd_valid and rst: rst wins and the command is not accepted.

Optional Feature:
- Macro: RECT_FILL_CHECKER_EN.
- When defined:
  - Adds input cmd_color_alt [DATA_WIDTH-1:0], captured at accept.
  - Each written pixel uses cmd_color_alt when (col^row)&1 == 1, otherwise cmd_color. Parity uses the relative counters, not px/py.
- When undefined: the port is absent and every pixel uses cmd_color.
- Timing is identical in both builds.

Test Plan:
- Reset, then x=0,y=0,w=2,h=2,color=0xF00 -> mem_we=1 with addr 0,1,320,321 in cycles 1-4, data 0xF00; done=1 in cycle 5; cmd_ready=1 in cycle 6.
- w=0 (h=5) -> no mem_we in any cycle; done in cycle 1; busy high for one cycle only.
- Right clip x=318,y=0,w=4,h=1 -> writes addr 318 and 319 in cycles 1-2; mem_we=0 in cycles 3-4; done in cycle 5.
- Bottom clip x=5,y=239,w=1,h=3 -> write addr 76485 in cycle 1; mem_we=0 in cycles 2-3; done in cycle 4.
- cmd_valid held high continuously with two commands queued (1x1 then 1x1) -> second accepted only after done plus one IDLE cycle; exactly two writes and two done pulses.
- 10x10 fill, rst asserted for one cycle after the 3rd write -> no writes after reset, no done pulse, cmd_ready=1 the cycle after reset.
- With RECT_FILL_CHECKER_EN, a 2x2 fill with color=0x000 and alt=0xFFF -> data sequence 0x000, 0xFFF, 0xFFF, 0x000.
